r8b_operand_fetch: RTL and testbench
====================================

Name: r8b_operand_fetch

Overview:
- Register-read/operand-fetch pipeline stage for the 8-bit pipelined CPU; sits directly around the r8b_gpr bank.
- Drives the one-hot LHS/RHS assert strobes and the load strobes/RegIn bus of every GPR.
- Samples the shared tri-state LHS/RHS buses, applies EX-stage forwarding, and hands latched operands to EX over a valid/ready handshake.
- Also routes write-back into the bank.

Parameters:
- NUM_REGS, 4, number of GPRs on the buses.
- SEL_W, 2, register-select width; must satisfy 2**SEL_W >= NUM_REGS.
- OP_W, 4, opcode field width carried through to EX.

Ports:
- clk  in  1  system clock; stage registers update on posedge (GPRs load on negedge).
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_lhs_sel  in  SEL_W  LHS source register.
- in_rhs_sel  in  SEL_W  RHS source register.
- in_dest_sel  in  SEL_W  destination register.
- in_dest_we  in  1  instruction writes its destination.
- in_op  in  OP_W  opcode.
- assert_lhs  out  NUM_REGS  one-hot, to GPR assert_LHS.
- assert_rhs  out  NUM_REGS  one-hot, to GPR assert_RHS.
- lhs_bus  in  8  shared LHS bus (GPR LhsOut).
- rhs_bus  in  8  shared RHS bus (GPR RhsOut).
- wb_valid  in  1  write-back request.
- wb_sel  in  SEL_W  write-back register.
- wb_data  in  8  write-back value.
- reg_load  out  NUM_REGS  one-hot, to GPR reg_load.
- reg_in  out  8  to GPR RegIn.
- fwd_valid  in  1  EX holds an instruction with in_dest_we set.
- fwd_dest  in  SEL_W  EX destination.
- fwd_data  in  8  EX result.
- fwd_pending  in  1  EX result not yet available (multi-cycle op).
- out_valid  out  1  operands valid to EX.
- out_ready  in  1  EX accepts.
- out_lhs  out  8  latched LHS operand.
- out_rhs  out  8  latched RHS operand.
- out_op  out  OP_W  latched opcode.
- out_dest_sel  out  SEL_W  latched destination.
- out_dest_we  out  1  latched write enable.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_lhs, out_rhs, out_op, out_dest_sel, out_dest_we = 0.
  - Combinational strobes are 0 while rst_n=0: assert_lhs, assert_rhs, reg_load all 0.
  - Release is synchronous to the next posedge.
- Hazard:
  - lhs_hit = fwd_valid && fwd_dest==in_lhs_sel; rhs_hit is the same with in_rhs_sel.
  - stall_hz = fwd_pending && (lhs_hit || rhs_hit).
- Handshake: in_ready = (!out_valid || out_ready) && !stall_hz. accept = in_valid && in_ready.
- Strobes (combinational):
  - assert_lhs[i] = accept && in_lhs_sel==i. assert_rhs is the same with in_rhs_sel.
  - No strobe is asserted when not accepting, so the buses float Z when idle.
  - LHS==RHS asserts the same index on both vectors; this is legal because they are separate buses.
- Operand select, per side, in priority order:
  1. forward hit -> fwd_data;
  2. sel >= NUM_REGS -> 8'h00;
  3. otherwise the bus value.
- Write-back:
  - reg_load[i] = wb_valid && wb_sel==i; reg_in = wb_data.
  - wb_sel >= NUM_REGS loads nothing.
  - The GPR captures at the mid-cycle negedge, so an operand read in the same cycle sees the new value (write-through); no WB bypass is needed.
  - A forward hit still overrides, because EX is younger than WB.
- Posedge update:
  - accept: load all out_* fields and set out_valid=1.
  - else if out_ready: out_valid=0.
  - else: hold all fields unchanged (the buses are not re-sampled).
- Latency: one cycle from accept to out_valid; full throughput of one per cycle when out_ready=1 and there is no hazard.
- Reset mid-operation: the in-flight operand is discarded and out_valid drops immediately.

Decomposition:
- Shared package r8b_pkg holds:
  - DATA_W=8, SEL_W, NUM_REGS, OP_W;
  - an operand-bundle typedef {op, lhs, rhs, dest_sel, dest_we}.
- One natural sub-module, r8b_sel_decode: binary select + enable -> one-hot NUM_REGS vector. It is instantiated three times (lhs, rhs, wb).

Test Plan:
- Reset, then a single read: GPR1=8'h3C, GPR2=8'hA5; instruction lhs=1, rhs=2, op=4'h3 with out_ready=1 -> assert_lhs=4'b0010 and assert_rhs=4'b0100 in the accept cycle; next posedge out_valid=1, out_lhs=8'h3C, out_rhs=8'hA5, out_op=3.
- Write-through: wb_valid, wb_sel=2, wb_data=8'h77 in the same cycle as a read of rhs=2 -> reg_load=4'b0100, reg_in=8'h77, out_rhs=8'h77.
- Forwarding: fwd_valid, fwd_dest=1, fwd_data=8'h55, fwd_pending=0; read lhs=1 with GPR1=8'h3C -> out_lhs=8'h55. Also assert wb_sel=1, wb_data=8'h99 in that cycle -> out_lhs is still 8'h55.
- Hazard stall: fwd_pending=1 with fwd_dest=lhs_sel -> in_ready=0 and assert_lhs=0 for 3 cycles. Drop fwd_pending with fwd_data=8'h12 -> accept and out_lhs=8'h12.
- Back-pressure: out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0, out_* held stable, no strobes. out_ready=1 -> the next instruction is accepted in that same cycle.
- Out-of-range and reset: with NUM_REGS=3, sel=3 -> no assert strobe and operand 8'h00. Asserting rst_n=0 while out_valid=1 -> out_valid=0 immediately, not waiting for a clock edge.

Source files
------------

// File: rtl/r8b_pkg.sv
// Shared constants and the operand bundle handed from operand fetch to EX
// in the r8b 8-bit pipelined CPU.
package r8b_pkg;

  localparam int DATA_W   = 8;
  localparam int SEL_W    = 2;
  localparam int NUM_REGS = 4;
  localparam int OP_W     = 4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] lhs;
    logic [DATA_W-1:0] rhs;
    logic [SEL_W-1:0]  dest_sel;
    logic              dest_we;
  } operand_t;

endpackage

// File: rtl/r8b_sel_decode.sv
// Binary register select plus enable to a one-hot strobe vector.
// Selects at or beyond NUM_REGS produce no strobe.
module r8b_sel_decode
  import r8b_pkg::*;
#(
  parameter int NUM_REGS = r8b_pkg::NUM_REGS,
  parameter int SEL_W    = r8b_pkg::SEL_W
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/r8b_operand_fetch.sv
// Operand fetch stage: drives GPR assert/load strobes, samples the shared
// LHS/RHS buses with EX forwarding, and hands operands to EX via valid/ready.
module r8b_operand_fetch
  import r8b_pkg::*;
#(
  parameter int NUM_REGS = r8b_pkg::NUM_REGS,
  parameter int SEL_W    = r8b_pkg::SEL_W,
  parameter int OP_W     = r8b_pkg::OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_lhs_sel,
  input  logic [SEL_W-1:0]    in_rhs_sel,
  input  logic [SEL_W-1:0]    in_dest_sel,
  input  logic                in_dest_we,
  input  logic [OP_W-1:0]     in_op,
  output logic [NUM_REGS-1:0] assert_lhs,
  output logic [NUM_REGS-1:0] assert_rhs,
  input  logic [DATA_W-1:0]   lhs_bus,
  input  logic [DATA_W-1:0]   rhs_bus,
  input  logic                wb_valid,
  input  logic [SEL_W-1:0]    wb_sel,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] reg_load,
  output logic [DATA_W-1:0]   reg_in,
  input  logic                fwd_valid,
  input  logic [SEL_W-1:0]    fwd_dest,
  input  logic [DATA_W-1:0]   fwd_data,
  input  logic                fwd_pending,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_lhs,
  output logic [DATA_W-1:0]   out_rhs,
  output logic [OP_W-1:0]     out_op,
  output logic [SEL_W-1:0]    out_dest_sel,
  output logic                out_dest_we
);

  logic                lhs_hit;
  logic                rhs_hit;
  logic                stall_hz;
  logic                accept;
  logic                vld_p0;
  logic [DATA_W-1:0]   lhs_p0;
  logic [DATA_W-1:0]   rhs_p0;
  logic [OP_W-1:0]     op_p0;
  logic [SEL_W-1:0]    dest_sel_p0;
  logic                dest_we_p0;

  // EX is younger than write-back, so its result beats anything on the bus.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              hit,
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] fwd,
    input logic [DATA_W-1:0] bus
  );
    if (hit)                       return fwd;
    else if (int'(sel) >= NUM_REGS) return '0;
    else                           return bus;
  endfunction

  assign lhs_hit  = fwd_valid && (fwd_dest == in_lhs_sel);
  assign rhs_hit  = fwd_valid && (fwd_dest == in_rhs_sel);
  assign stall_hz = fwd_pending && (lhs_hit || rhs_hit);
  assign in_ready = (!vld_p0 || out_ready) && !stall_hz;
  // Gating with rst_n keeps every bus strobe quiet while the core is in reset.
  assign accept   = rst_n && in_valid && in_ready;
  assign reg_in   = wb_data;

  r8b_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_lhs (
    .en     (accept),
    .sel    (in_lhs_sel),
    .onehot (assert_lhs)
  );

  r8b_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_rhs (
    .en     (accept),
    .sel    (in_rhs_sel),
    .onehot (assert_rhs)
  );

  // GPRs load on the negedge, so a same-cycle read already sees wb_data.
  r8b_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_wb (
    .en     (rst_n && wb_valid),
    .sel    (wb_sel),
    .onehot (reg_load)
  );

  // Stage boundary: fetch -> EX operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      lhs_p0      <= '0;
      rhs_p0      <= '0;
      op_p0       <= '0;
      dest_sel_p0 <= '0;
      dest_we_p0  <= 1'b0;
    end else if (accept) begin
      vld_p0      <= 1'b1;
      lhs_p0      <= pick_operand(lhs_hit, in_lhs_sel, fwd_data, lhs_bus);
      rhs_p0      <= pick_operand(rhs_hit, in_rhs_sel, fwd_data, rhs_bus);
      op_p0       <= in_op;
      dest_sel_p0 <= in_dest_sel;
      dest_we_p0  <= in_dest_we;
    end else if (out_ready) begin
      vld_p0      <= 1'b0;
    end
  end

  assign out_valid    = vld_p0;
  assign out_lhs      = lhs_p0;
  assign out_rhs      = rhs_p0;
  assign out_op       = op_p0;
  assign out_dest_sel = dest_sel_p0;
  assign out_dest_we  = dest_we_p0;

endmodule

// File: tb/tb_r8b_operand_fetch.sv
// Bench for r8b_operand_fetch with a three-register behavioural GPR bank.
// An undriven bus reads as 8'hEE so stray bus sampling is visible.
module tb_r8b_operand_fetch;

  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    in_lhs_sel, in_rhs_sel, in_dest_sel;
  logic          in_dest_we;
  logic [3:0]    in_op;
  logic [NR-1:0] assert_lhs, assert_rhs, reg_load;
  logic [7:0]    lhs_bus, rhs_bus;
  logic          wb_valid;
  logic [1:0]    wb_sel;
  logic [7:0]    wb_data, reg_in;
  logic          fwd_valid, fwd_pending;
  logic [1:0]    fwd_dest;
  logic [7:0]    fwd_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_lhs, out_rhs;
  logic [3:0]    out_op;
  logic [1:0]    out_dest_sel;
  logic          out_dest_we;

  int checks = 0;
  int failures = 0;

  logic [7:0] gpr [NR];

  always #5 clk = ~clk;

  r8b_operand_fetch #(.NUM_REGS(NR), .SEL_W(2), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lhs_sel(in_lhs_sel), .in_rhs_sel(in_rhs_sel),
    .in_dest_sel(in_dest_sel), .in_dest_we(in_dest_we), .in_op(in_op),
    .assert_lhs(assert_lhs), .assert_rhs(assert_rhs),
    .lhs_bus(lhs_bus), .rhs_bus(rhs_bus),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .reg_load(reg_load), .reg_in(reg_in),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lhs(out_lhs), .out_rhs(out_rhs), .out_op(out_op),
    .out_dest_sel(out_dest_sel), .out_dest_we(out_dest_we)
  );

  initial for (int i = 0; i < NR; i++) gpr[i] = 8'h00;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (reg_load[i]) gpr[i] <= reg_in;
  end

  always_comb begin
    lhs_bus = 8'hEE;
    rhs_bus = 8'hEE;
    for (int i = 0; i < NR; i++) begin
      if (assert_lhs[i]) lhs_bus = gpr[i];
      if (assert_rhs[i]) rhs_bus = gpr[i];
    end
  end

  typedef struct {
    logic iv; logic [1:0] ls, rs, ds; logic dwe; logic [3:0] op;
    logic wv; logic [1:0] ws; logic [7:0] wd;
    logic fv; logic [1:0] fd; logic [7:0] fdat; logic fp; logic ordy;
    logic e_ir; logic [2:0] e_al, e_ar, e_rl;
    logic e_ov; logic [7:0] e_ol, e_or; logic [3:0] e_op; logic [1:0] e_ds; logic e_dwe;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; in_lhs_sel = v.ls; in_rhs_sel = v.rs;
    in_dest_sel = v.ds; in_dest_we = v.dwe; in_op = v.op;
    wb_valid = v.wv; wb_sel = v.ws; wb_data = v.wd;
    fwd_valid = v.fv; fwd_dest = v.fd; fwd_data = v.fdat; fwd_pending = v.fp;
    out_ready = v.ordy;
  endtask

  task automatic set_instr(input logic iv, input logic [1:0] ls, input logic [1:0] rs,
                           input logic [1:0] ds, input logic dwe, input logic [3:0] op);
    in_valid = iv; in_lhs_sel = ls; in_rhs_sel = rs;
    in_dest_sel = ds; in_dest_we = dwe; in_op = op;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 4'h0);
    wb_valid = 1'b1; wb_sel = 2'd0; wb_data = 8'h5A;
    fwd_valid = 1'b0; fwd_dest = 2'd0; fwd_data = 8'h00; fwd_pending = 1'b0;
    out_ready = 1'b1;

    //                iv ls rs ds dwe op    wv ws wd     fv fd fdat   fp ordy  ir al      ar      rl      ov ol     or     op    ds dwe
    tbl[0]  = '{1'b0,2'd0,2'd0,2'd0,1'b0,4'h0, 1'b1,2'd1,8'h3C, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b000,3'b000,3'b010, 1'b0,8'h00,8'h00,4'h0,2'd0,1'b0};
    tbl[1]  = '{1'b0,2'd0,2'd0,2'd0,1'b0,4'h0, 1'b1,2'd2,8'hA5, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b000,3'b000,3'b100, 1'b0,8'h00,8'h00,4'h0,2'd0,1'b0};
    tbl[2]  = '{1'b1,2'd1,2'd2,2'd0,1'b1,4'h3, 1'b0,2'd0,8'h00, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b010,3'b100,3'b000, 1'b1,8'h3C,8'hA5,4'h3,2'd0,1'b1};
    tbl[3]  = '{1'b1,2'd0,2'd2,2'd2,1'b0,4'h5, 1'b1,2'd2,8'h77, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b001,3'b100,3'b100, 1'b1,8'h00,8'h77,4'h5,2'd2,1'b0};
    tbl[4]  = '{1'b1,2'd1,2'd0,2'd1,1'b1,4'h6, 1'b1,2'd1,8'h99, 1'b1,2'd1,8'h55,1'b0,1'b1, 1'b1,3'b010,3'b001,3'b010, 1'b1,8'h55,8'h00,4'h6,2'd1,1'b1};
    tbl[5]  = '{1'b1,2'd3,2'd1,2'd2,1'b1,4'h9, 1'b0,2'd0,8'h00, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b000,3'b010,3'b000, 1'b1,8'h00,8'h99,4'h9,2'd2,1'b1};
    tbl[6]  = '{1'b1,2'd2,2'd2,2'd0,1'b0,4'hA, 1'b0,2'd0,8'h00, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b100,3'b100,3'b000, 1'b1,8'h77,8'h77,4'hA,2'd0,1'b0};
    tbl[7]  = '{1'b1,2'd0,2'd3,2'd1,1'b1,4'hB, 1'b0,2'd0,8'h00, 1'b1,2'd3,8'h42,1'b0,1'b1, 1'b1,3'b001,3'b000,3'b000, 1'b1,8'h00,8'h42,4'hB,2'd1,1'b1};
    tbl[8]  = '{1'b0,2'd0,2'd0,2'd0,1'b0,4'h0, 1'b0,2'd0,8'h00, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b000,3'b000,3'b000, 1'b0,8'h00,8'h42,4'hB,2'd1,1'b1};
    tbl[9]  = '{1'b0,2'd0,2'd0,2'd0,1'b0,4'h0, 1'b1,2'd3,8'hFF, 1'b0,2'd0,8'h00,1'b0,1'b1, 1'b1,3'b000,3'b000,3'b000, 1'b0,8'h00,8'h42,4'hB,2'd1,1'b1};
    tbl[10] = '{1'b1,2'd1,2'd2,2'd2,1'b0,4'hC, 1'b0,2'd0,8'h00, 1'b1,2'd0,8'h33,1'b1,1'b1, 1'b1,3'b010,3'b100,3'b000, 1'b1,8'h99,8'h77,4'hC,2'd2,1'b0};

    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_lhs", 32'(out_lhs), 32'h0);
    chk("rst_out_rhs", 32'(out_rhs), 32'h0);
    chk("rst_out_op", 32'(out_op), 32'h0);
    chk("rst_out_dest", 32'({out_dest_sel, out_dest_we}), 32'h0);
    chk("rst_assert_lhs", 32'(assert_lhs), 32'h0);
    chk("rst_assert_rhs", 32'(assert_rhs), 32'h0);
    chk("rst_reg_load", 32'(reg_load), 32'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 11; r++) begin
      drive(tbl[r]);
      #2;
      chk($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].e_ir));
      chk($sformatf("row%0d_assert_lhs", r), 32'(assert_lhs), 32'(tbl[r].e_al));
      chk($sformatf("row%0d_assert_rhs", r), 32'(assert_rhs), 32'(tbl[r].e_ar));
      chk($sformatf("row%0d_reg_load", r), 32'(reg_load), 32'(tbl[r].e_rl));
      if (tbl[r].wv) chk($sformatf("row%0d_reg_in", r), 32'(reg_in), 32'(tbl[r].wd));
      step();
      chk($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
      chk($sformatf("row%0d_out_lhs", r), 32'(out_lhs), 32'(tbl[r].e_ol));
      chk($sformatf("row%0d_out_rhs", r), 32'(out_rhs), 32'(tbl[r].e_or));
      chk($sformatf("row%0d_out_op", r), 32'(out_op), 32'(tbl[r].e_op));
      chk($sformatf("row%0d_out_dest_sel", r), 32'(out_dest_sel), 32'(tbl[r].e_ds));
      chk($sformatf("row%0d_out_dest_we", r), 32'(out_dest_we), 32'(tbl[r].e_dwe));
    end

    // Pending EX result on the LHS source holds the instruction for three cycles.
    wb_valid = 1'b0; out_ready = 1'b1;
    set_instr(1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 4'h7);
    fwd_valid = 1'b1; fwd_dest = 2'd1; fwd_data = 8'h00; fwd_pending = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("hz%0d_in_ready", c), 32'(in_ready), 32'h0);
      chk($sformatf("hz%0d_assert_lhs", c), 32'(assert_lhs), 32'h0);
      chk($sformatf("hz%0d_assert_rhs", c), 32'(assert_rhs), 32'h0);
      step();
      chk($sformatf("hz%0d_out_valid", c), 32'(out_valid), 32'h0);
    end
    fwd_pending = 1'b0; fwd_data = 8'h12;
    #2;
    chk("hz_release_in_ready", 32'(in_ready), 32'h1);
    chk("hz_release_assert_lhs", 32'(assert_lhs), 32'b010);
    step();
    chk("hz_out_valid", 32'(out_valid), 32'h1);
    chk("hz_out_lhs", 32'(out_lhs), 32'h12);
    chk("hz_out_rhs", 32'(out_rhs), 32'h00);
    chk("hz_out_op", 32'(out_op), 32'h7);

    // EX back-pressure: operand register holds and nothing is strobed.
    fwd_valid = 1'b0; out_ready = 1'b0;
    set_instr(1'b1, 2'd2, 2'd1, 2'd2, 1'b0, 4'h8);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'h0);
      chk($sformatf("bp%0d_strobes", c), 32'({assert_lhs, assert_rhs}), 32'h0);
      step();
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'h1);
      chk($sformatf("bp%0d_out_lhs", c), 32'(out_lhs), 32'h12);
      chk($sformatf("bp%0d_out_op", c), 32'(out_op), 32'h7);
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    chk("bp_release_assert_lhs", 32'(assert_lhs), 32'b100);
    chk("bp_release_assert_rhs", 32'(assert_rhs), 32'b010);
    step();
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_out_lhs", 32'(out_lhs), 32'h77);
    chk("bp_out_rhs", 32'(out_rhs), 32'h99);
    chk("bp_out_op", 32'(out_op), 32'h8);
    chk("bp_out_dest", 32'({out_dest_sel, out_dest_we}), 32'b100);

    // Asynchronous reset while an operand is held for EX.
    set_instr(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 4'hD);
    wb_valid = 1'b1; wb_sel = 2'd0; wb_data = 8'hAB;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_lhs", 32'(out_lhs), 32'h0);
    chk("arst_out_op", 32'(out_op), 32'h0);
    chk("arst_strobes", 32'({assert_lhs, assert_rhs}), 32'h0);
    chk("arst_reg_load", 32'(reg_load), 32'h0);
    in_valid = 1'b0; wb_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    set_instr(1'b1, 2'd0, 2'd1, 2'd1, 1'b1, 4'hE);
    #2;
    chk("post_rst_assert_lhs", 32'(assert_lhs), 32'b001);
    step();
    chk("post_rst_out_valid2", 32'(out_valid), 32'h1);
    chk("post_rst_out_lhs", 32'(out_lhs), 32'h00);
    chk("post_rst_out_rhs", 32'(out_rhs), 32'h99);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
